// File: rtl/exe_wb_skid_pkg.sv
// Shared widths and the EXE result record for the EXE->MEM/WB skid buffer.
package exe_wb_skid_pkg;

    localparam int RSZ     = 32;
    localparam int GPR_ASZ = 5;
    localparam int PC_SZ   = 32;

    typedef struct packed {
        logic [RSZ-1:0]     rd_data;
        logic [GPR_ASZ-1:0] rd_addr;
        logic               rd_wr;
        logic [PC_SZ-1:0]   pc;
    } EXE_RESULT_T;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } count_e;

    // Writes to x0 are architecturally discarded, so the enable is dropped at capture.
    function automatic EXE_RESULT_T capture_result(
        input logic [RSZ-1:0]     rd_data,
        input logic [GPR_ASZ-1:0] rd_addr,
        input logic               rd_wr,
        input logic [PC_SZ-1:0]   pc
    );
        EXE_RESULT_T r;
        r.rd_data = rd_data;
        r.rd_addr = rd_addr;
        r.rd_wr   = rd_wr & (rd_addr != '0);
        r.pc      = pc;
        return r;
    endfunction

endpackage

// File: rtl/exe_wb_skid.sv
// Two-entry elastic buffer between the EXE result mux and MEM/WB; outputs come only from the head register.
module exe_wb_skid
    import exe_wb_skid_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               flush_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RSZ-1:0]     in_rd_data,
    input  logic [GPR_ASZ-1:0] in_rd_addr,
    input  logic               in_rd_wr,
    input  logic [PC_SZ-1:0]   in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RSZ-1:0]     out_rd_data,
    output logic [GPR_ASZ-1:0] out_rd_addr,
    output logic               out_rd_wr,
    output logic [PC_SZ-1:0]   out_pc,
    output logic [1:0]         occupancy
);

    count_e      r_count;
    EXE_RESULT_T r_head;
    EXE_RESULT_T r_skid;

    logic        w_push;
    logic        w_pop;
    EXE_RESULT_T w_cap;

    // Ready/valid come from the registered count only, so out_ready never reaches in_ready.
    assign in_ready  = (r_count != CNT_TWO);
    assign out_valid = (r_count != CNT_EMPTY);

    always_comb begin
        w_push = in_valid & in_ready;
        w_pop  = out_valid & out_ready;
        w_cap  = capture_result(in_rd_data, in_rd_addr, in_rd_wr, in_pc);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_count <= CNT_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (flush_in) begin
            r_count      <= CNT_EMPTY;
            r_head.rd_wr <= 1'b0;
        end else begin
            case (r_count)
                CNT_EMPTY: begin
                    if (w_push) begin
                        r_head  <= w_cap;
                        r_count <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_skid  <= w_cap;
                            r_count <= CNT_TWO;
                        end
                        2'b11: r_head  <= w_cap;
                        2'b01: r_count <= CNT_EMPTY;
                        default: ;
                    endcase
                end
                CNT_TWO: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_count <= CNT_ONE;
                    end
                end
                default: r_count <= CNT_EMPTY;
            endcase
        end
    end

    assign out_rd_data = r_head.rd_data;
    assign out_rd_addr = r_head.rd_addr;
    assign out_rd_wr   = r_head.rd_wr;
    assign out_pc      = r_head.pc;
    assign occupancy   = r_count;

endmodule

// File: tb/tb_exe_wb_skid.sv
// Directed bench for exe_wb_skid: reset, latency, fill/drain, streaming order, x0, flush, async reset.
module tb_exe_wb_skid;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        flush_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rd_data;
    logic [4:0]  in_rd_addr;
    logic        in_rd_wr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd_data;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wr;
    logic [31:0] out_pc;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    exe_wb_skid dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .flush_in    (flush_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd_data  (in_rd_data),
        .in_rd_addr  (in_rd_addr),
        .in_rd_wr    (in_rd_wr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd_data (out_rd_data),
        .out_rd_addr (out_rd_addr),
        .out_rd_wr   (out_rd_wr),
        .out_pc      (out_pc),
        .occupancy   (occupancy)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                         input logic w, input logic [31:0] pc);
        in_valid   = v;
        in_rd_data = d;
        in_rd_addr = a;
        in_rd_wr   = w;
        in_pc      = pc;
    endtask

    task automatic test_reset();
        reset_in  = 1'b0;
        flush_in  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #2;
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags got v=%b r=%b occ=%0d exp v=0 r=1 occ=0", out_valid, in_ready, occupancy);
        end
        checks++;
        if ({out_rd_data, out_rd_addr, out_rd_wr, out_pc} !== 70'h0) begin
            errors++;
            $display("FAIL reset_data got d=%h a=%0d w=%b pc=%h exp all zero", out_rd_data, out_rd_addr, out_rd_wr, out_pc);
        end
        #10 reset_in = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_1234, 5'd5, 1'b1, 32'h100);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL basic_valid got v=%b occ=%0d exp v=1 occ=1", out_valid, occupancy);
        end
        checks++;
        if (out_rd_data !== 32'h1234 || out_rd_addr !== 5'd5 || out_rd_wr !== 1'b1 || out_pc !== 32'h100) begin
            errors++;
            $display("FAIL basic_data got d=%h a=%0d w=%b pc=%h exp d=00001234 a=5 w=1 pc=00000100",
                     out_rd_data, out_rd_addr, out_rd_wr, out_pc);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_AAAA, 5'd1, 1'b1, 32'h200);
        tick();
        drive(1'b1, 32'hBBBB_BBBB, 5'd2, 1'b1, 32'h204);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_rd_data !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL fill_full got occ=%0d r=%b d=%h exp occ=2 r=0 d=aaaaaaaa", occupancy, in_ready, out_rd_data);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready_indep got r=%b exp r=0", in_ready);
        end
        tick();
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_rd_data !== 32'hBBBB_BBBB || out_pc !== 32'h204) begin
            errors++;
            $display("FAIL fill_pop got occ=%0d r=%b d=%h pc=%h exp occ=1 r=1 d=bbbbbbbb pc=00000204",
                     occupancy, in_ready, out_rd_data, out_pc);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL fill_drain got occ=%0d exp 0", occupancy);
        end
    endtask

    task automatic test_back_to_back();
        int tx = 0;
        int rx = 0;
        int mcount = 0;
        int cyc = 0;
        logic push, pop;
        while (rx < 10 && cyc < 60) begin
            out_ready = (cyc % 2 == 0);
            drive(tx < 10, 32'h5000 + tx, 5'(tx + 1), 1'b1, 32'h1000 + 4 * tx);
            #1;
            checks++;
            if (in_ready !== (mcount != 2) || occupancy !== 2'(mcount)) begin
                errors++;
                $display("FAIL stream_state cyc=%0d got r=%b occ=%0d exp r=%b occ=%0d",
                         cyc, in_ready, occupancy, (mcount != 2), mcount);
            end
            push = in_valid && (mcount != 2);
            pop  = (mcount != 0) && out_ready;
            if (pop) begin
                checks++;
                if (out_rd_data !== 32'h5000 + rx || out_rd_addr !== 5'(rx + 1)) begin
                    errors++;
                    $display("FAIL stream_order idx=%0d got d=%h a=%0d exp d=%h a=%0d",
                             rx, out_rd_data, out_rd_addr, 32'h5000 + rx, rx + 1);
                end
                rx++;
            end
            @(posedge clk_in);
            #1;
            mcount = mcount + (push ? 1 : 0) - (pop ? 1 : 0);
            if (push) tx++;
            cyc++;
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        out_ready = 1'b0;
        checks++;
        if (rx != 10 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_done got rx=%0d occ=%0d exp rx=10 occ=0", rx, occupancy);
        end
    endtask

    task automatic test_x0();
        out_ready = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'h300);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_rd_wr !== 1'b0 || out_rd_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL x0_rule got v=%b w=%b d=%h exp v=1 w=0 d=deadbeef", out_valid, out_rd_wr, out_rd_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd3, 1'b1, 32'h400);
        tick();
        drive(1'b1, 32'h22, 5'd4, 1'b1, 32'h404);
        tick();
        flush_in = 1'b1;
        drive(1'b1, 32'h33, 5'd6, 1'b1, 32'h408);
        #1;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre got occ=%0d r=%b exp occ=2 r=0", occupancy, in_ready);
        end
        tick();
        flush_in = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_rd_wr !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got occ=%0d v=%b w=%b r=%b exp occ=0 v=0 w=0 r=1",
                     occupancy, out_valid, out_rd_wr, in_ready);
        end
        drive(1'b1, 32'h44, 5'd7, 1'b1, 32'h40C);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (occupancy !== 2'd1 || out_rd_data !== 32'h44) begin
            errors++;
            $display("FAIL flush_after got occ=%0d d=%h exp occ=1 d=00000044", occupancy, out_rd_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 5'd8, 1'b1, 32'h500);
        tick();
        drive(1'b1, 32'h66, 5'd9, 1'b1, 32'h504);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #2 reset_in = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b occ=%0d r=%b d=%h exp v=0 occ=0 r=1 d=0",
                     out_valid, occupancy, in_ready, out_rd_data);
        end
        tick();
        #2 reset_in = 1'b1;
        tick();
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_x0();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
